// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared byte constants, echo-engine state encoding and the
//                ASCII upper-case folding helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;
    localparam logic [7:0] CHAR_SP  = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SEND   = 3'd2,
        S_WAIT   = 3'd3,
        S_REPLAY = 3'd4
    } state_t;

    // Map 'a'..'z' onto 'A'..'Z'; every other byte passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b >= 8'h61 && b <= 8'h7A) begin
            r = b - 8'h20;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_fifo
//  Description : Synchronous byte FIFO with a registered read port. A popped
//                byte appears on rd_data the cycle after rd_en and stays there
//                until the next pop. A write on a full FIFO is accepted only
//                when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [7:0]    mem_q [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    rd_data_q;
    logic          w_do_wr;
    logic          w_do_rd;

    assign full    = (count_q == C_DEPTH);
    assign empty   = (count_q == '0);
    assign w_do_rd = rd_en && !empty;
    // A pop frees the slot the write lands in, so full+pop still accepts.
    assign w_do_wr = wr_en && (!full || w_do_rd);
    assign rd_data = rd_data_q;

    // Storage array; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy count and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
        end else begin
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (w_do_wr && !w_do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (!w_do_wr && w_do_rd) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_line_echo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_line_echo
//  Description : Echo / line-editing engine between uart_rx and uart_tx.
//                Received bytes are queued, decoded into 0-3 byte responses
//                (character echo) or collected into a line buffer that is
//                replayed on CR (line replay). Backspace editing, optional
//                upper-case folding on transmit, overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_line_echo
    import uart_pkg::*;
#(
    parameter int LINE_DEPTH = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int ECHO_MODE  = 1,
    parameter int UPPERCASE  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_byte,
    input  logic                            tx_active,
    input  logic                            tx_done,
    output logic                            tx_valid,
    output logic [7:0]                      tx_data,
    output logic [7:0]                      last_char,
    output logic [$clog2(LINE_DEPTH+1)-1:0] line_len,
    output logic                            line_done,
    output logic                            line_overflow,
    output logic                            rx_overflow
);

    localparam int LEN_W = $clog2(LINE_DEPTH + 1);
    localparam int IDX_W = $clog2(LINE_DEPTH);
    localparam logic [LEN_W-1:0] C_LINE_FULL = LEN_W'(LINE_DEPTH);

    state_t          state_q, state_d;
    logic [LEN_W-1:0] line_len_q, line_len_d;
    logic [LEN_W-1:0] rep_idx_q, rep_idx_d;
    logic [2:0][7:0] seq_q, seq_d;
    logic [1:0]      seq_len_q, seq_len_d;
    logic [1:0]      seq_idx_q, seq_idx_d;
    logic            replay_q, replay_d;
    logic            line_end_q, line_end_d;
    logic [7:0]      rep_byte_q, rep_byte_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            line_done_q, line_done_d;
    logic            line_ovf_q, line_ovf_d;
    logic            rx_ovf_q, rx_ovf_d;

    logic [7:0]      line_buf_q [0:LINE_DEPTH-1];
    logic            w_buf_we;
    logic [7:0]      w_buf_rd;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [7:0]      w_cur;
    logic            w_drop;
    logic [7:0]      w_tx_byte;

    // The FIFO read register doubles as last_char: it changes only on a pop.
    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_valid),
        .wr_data (rx_byte),
        .rd_en   (w_pop),
        .rd_data (w_cur),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign w_drop    = rx_valid && w_fifo_full && !w_pop;
    assign w_buf_rd  = line_buf_q[rep_idx_q[IDX_W-1:0]];
    assign w_tx_byte = replay_q ? rep_byte_q : seq_q[seq_idx_q];

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign last_char     = w_cur;
    assign line_len      = line_len_q;
    assign line_done     = line_done_q;
    assign line_overflow = line_ovf_q;
    assign rx_overflow   = rx_ovf_q;

    // Line buffer storage; holds raw bytes, folding happens only at tx_data.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            line_buf_q[line_len_q[IDX_W-1:0]] <= w_cur;
        end
    end

    // Next-state logic: decode, response sequencing, replay walk, line end.
    always_comb begin
        state_d     = state_q;
        line_len_d  = line_len_q;
        rep_idx_d   = rep_idx_q;
        seq_d       = seq_q;
        seq_len_d   = seq_len_q;
        seq_idx_d   = seq_idx_q;
        replay_d    = replay_q;
        line_end_d  = line_end_q;
        rep_byte_d  = rep_byte_q;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        line_done_d = 1'b0;
        line_ovf_d  = line_ovf_q;
        rx_ovf_d    = rx_ovf_q | w_drop;
        w_pop       = 1'b0;
        w_buf_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                seq_idx_d  = 2'd0;
                replay_d   = 1'b0;
                line_end_d = 1'b0;
                state_d    = S_IDLE;
                if (w_cur == CHAR_CR) begin
                    if (ECHO_MODE != 0) begin
                        seq_d[0]   = CHAR_CR;
                        seq_d[1]   = CHAR_LF;
                        seq_len_d  = 2'd2;
                        line_end_d = 1'b1;
                        state_d    = S_SEND;
                    end else begin
                        replay_d  = 1'b1;
                        rep_idx_d = '0;
                        state_d   = S_REPLAY;
                    end
                end else if (w_cur == CHAR_LF) begin
                    state_d = S_IDLE;
                end else if (w_cur == CHAR_BS || w_cur == CHAR_DEL) begin
                    if (line_len_q != '0) begin
                        line_len_d = line_len_q - 1'b1;
                        if (ECHO_MODE != 0) begin
                            seq_d[0]  = CHAR_BS;
                            seq_d[1]  = CHAR_SP;
                            seq_d[2]  = CHAR_BS;
                            seq_len_d = 2'd3;
                            state_d   = S_SEND;
                        end
                    end
                end else if (line_len_q < C_LINE_FULL) begin
                    w_buf_we   = 1'b1;
                    line_len_d = line_len_q + 1'b1;
                    if (ECHO_MODE != 0) begin
                        seq_d[0]  = w_cur;
                        seq_len_d = 2'd1;
                        state_d   = S_SEND;
                    end
                end else begin
                    line_ovf_d = 1'b1;
                end
            end

            S_REPLAY: begin
                if (rep_idx_q < line_len_q) begin
                    rep_byte_d = w_buf_rd;
                    state_d    = S_SEND;
                end else begin
                    // Buffer exhausted: finish the line with CR LF.
                    replay_d   = 1'b0;
                    seq_d[0]   = CHAR_CR;
                    seq_d[1]   = CHAR_LF;
                    seq_len_d  = 2'd2;
                    seq_idx_d  = 2'd0;
                    line_end_d = 1'b1;
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                // Hold off while uart_tx is still shifting an earlier byte.
                if (!tx_active) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = (UPPERCASE != 0) ? to_upper(w_tx_byte) : w_tx_byte;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (tx_done) begin
                    if (replay_q) begin
                        rep_idx_d = rep_idx_q + 1'b1;
                        state_d   = S_REPLAY;
                    end else if (seq_idx_q + 2'd1 < seq_len_q) begin
                        seq_idx_d = seq_idx_q + 2'd1;
                        state_d   = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                        if (line_end_q) begin
                            line_len_d  = '0;
                            line_ovf_d  = 1'b0;
                            line_done_d = 1'b1;
                            line_end_d  = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            line_len_q  <= '0;
            rep_idx_q   <= '0;
            seq_q       <= '0;
            seq_len_q   <= 2'd0;
            seq_idx_q   <= 2'd0;
            replay_q    <= 1'b0;
            line_end_q  <= 1'b0;
            rep_byte_q  <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            line_done_q <= 1'b0;
            line_ovf_q  <= 1'b0;
            rx_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_len_q  <= line_len_d;
            rep_idx_q   <= rep_idx_d;
            seq_q       <= seq_d;
            seq_len_q   <= seq_len_d;
            seq_idx_q   <= seq_idx_d;
            replay_q    <= replay_d;
            line_end_q  <= line_end_d;
            rep_byte_q  <= rep_byte_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            line_done_q <= line_done_d;
            line_ovf_q  <= line_ovf_d;
            rx_ovf_q    <= rx_ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_line_echo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_line_echo
//  Description : Self-checking bench for uart_line_echo. Three instances:
//                A = echo mode, 64-byte line; B = replay mode, 4-byte line,
//                upper-case folding; C = echo mode, 2-deep FIFO.
//                A simple uart_tx model records every transmitted byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_line_echo;

    localparam int TX_CYC = 6;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] rx_valid_v;
    logic [7:0] rx_byte_v [3];
    logic [2:0] tx_active_v;
    logic [2:0] tx_done_v;
    logic [2:0] hold_v;

    wire  [2:0] tx_valid_w;
    wire  [7:0] tx_data_w [3];
    wire  [7:0] last_char_w [3];
    wire  [2:0] line_done_w;
    wire  [2:0] line_ovf_w;
    wire  [2:0] rx_ovf_w;
    wire  [6:0] ll0;
    wire  [2:0] ll1;
    wire  [6:0] ll2;

    int checks   = 0;
    int failures = 0;

    byte unsigned txq [3][$];
    int           ndone [3];
    int           viol  [3];
    int           busy  [3];

    byte unsigned stim [$];
    byte unsigned expq [$];
    byte unsigned mline [$];
    bit           movf;

    always #5 clk = ~clk;

    uart_line_echo #(.LINE_DEPTH(64), .FIFO_DEPTH(8), .ECHO_MODE(1), .UPPERCASE(0)) dut_a (
        .clk(clk), .rst(rst_v[0]), .rx_valid(rx_valid_v[0]), .rx_byte(rx_byte_v[0]),
        .tx_active(tx_active_v[0]), .tx_done(tx_done_v[0]), .tx_valid(tx_valid_w[0]),
        .tx_data(tx_data_w[0]), .last_char(last_char_w[0]), .line_len(ll0),
        .line_done(line_done_w[0]), .line_overflow(line_ovf_w[0]), .rx_overflow(rx_ovf_w[0]));

    uart_line_echo #(.LINE_DEPTH(4), .FIFO_DEPTH(8), .ECHO_MODE(0), .UPPERCASE(1)) dut_b (
        .clk(clk), .rst(rst_v[1]), .rx_valid(rx_valid_v[1]), .rx_byte(rx_byte_v[1]),
        .tx_active(tx_active_v[1]), .tx_done(tx_done_v[1]), .tx_valid(tx_valid_w[1]),
        .tx_data(tx_data_w[1]), .last_char(last_char_w[1]), .line_len(ll1),
        .line_done(line_done_w[1]), .line_overflow(line_ovf_w[1]), .rx_overflow(rx_ovf_w[1]));

    uart_line_echo #(.LINE_DEPTH(64), .FIFO_DEPTH(2), .ECHO_MODE(1), .UPPERCASE(0)) dut_c (
        .clk(clk), .rst(rst_v[2]), .rx_valid(rx_valid_v[2]), .rx_byte(rx_byte_v[2]),
        .tx_active(tx_active_v[2]), .tx_done(tx_done_v[2]), .tx_valid(tx_valid_w[2]),
        .tx_data(tx_data_w[2]), .last_char(last_char_w[2]), .line_len(ll2),
        .line_done(line_done_w[2]), .line_overflow(line_ovf_w[2]), .rx_overflow(rx_ovf_w[2]));

    // uart_tx model: capture on tx_valid, stay busy TX_CYC cycles (frozen
    // while hold is set), then pulse tx_done. Also counts line_done pulses
    // and any request raised while busy.
    initial begin
        tx_active_v = 3'b000;
        tx_done_v   = 3'b000;
        for (int g = 0; g < 3; g++) begin
            ndone[g] = 0; viol[g] = 0; busy[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                tx_done_v[g] = 1'b0;
                if (line_done_w[g]) ndone[g]++;
                if (busy[g] != 0) begin
                    if (tx_valid_w[g]) viol[g]++;
                    if (!hold_v[g]) begin
                        busy[g]--;
                        if (busy[g] == 0) begin
                            tx_active_v[g] = 1'b0;
                            tx_done_v[g]   = 1'b1;
                        end
                    end
                end else if (tx_valid_w[g]) begin
                    txq[g].push_back(tx_data_w[g]);
                    busy[g]        = TX_CYC;
                    tx_active_v[g] = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] len_of(input int g);
        if (g == 0) return {25'd0, ll0};
        if (g == 1) return {29'd0, ll1};
        return {25'd0, ll2};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int g, input byte unsigned b);
        @(negedge clk);
        rx_valid_v[g] = 1'b1;
        rx_byte_v[g]  = b;
        @(negedge clk);
        rx_valid_v[g] = 1'b0;
    endtask

    task automatic drive_stim(input int g, input int gap);
        foreach (stim[i]) begin
            send(g, stim[i]);
            idle(gap);
        end
    endtask

    task automatic check_reset(input int g, input string p);
        chk($sformatf("%s_tx_valid%0d", p, g),  32'(tx_valid_w[g]), 0);
        chk($sformatf("%s_tx_data%0d", p, g),   32'(tx_data_w[g]), 0);
        chk($sformatf("%s_last_char%0d", p, g), 32'(last_char_w[g]), 0);
        chk($sformatf("%s_line_len%0d", p, g),  len_of(g), 0);
        chk($sformatf("%s_line_done%0d", p, g), 32'(line_done_w[g]), 0);
        chk($sformatf("%s_line_ovf%0d", p, g),  32'(line_ovf_w[g]), 0);
        chk($sformatf("%s_rx_ovf%0d", p, g),    32'(rx_ovf_w[g]), 0);
    endtask

    task automatic cmp_stream(input int g, input int s, input string tag);
        chk({tag, "_count"}, 32'(txq[g].size() - s), 32'(expq.size()));
        for (int i = 0; i < expq.size() && (s + i) < txq[g].size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(txq[g][s + i]), 32'(expq[i]));
        end
    endtask

    function automatic byte unsigned fold(input byte unsigned b, input bit up);
        if (up && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    // Reference behaviour: a line is a queue of characters; compute what the
    // terminal should see for the bytes in stim.
    task automatic run_model(input int depth, input bit echo, input bit up);
        expq.delete();
        mline.delete();
        movf = 1'b0;
        foreach (stim[i]) begin
            byte unsigned b;
            b = stim[i];
            if (b == 8'h0D) begin
                if (!echo) foreach (mline[j]) expq.push_back(fold(mline[j], up));
                expq.push_back(8'h0D);
                expq.push_back(8'h0A);
                mline.delete();
                movf = 1'b0;
            end else if (b == 8'h0A) begin
                // ignored
            end else if (b == 8'h08 || b == 8'h7F) begin
                if (mline.size() > 0) begin
                    void'(mline.pop_back());
                    if (echo) begin
                        expq.push_back(8'h08); expq.push_back(8'h20); expq.push_back(8'h08);
                    end
                end
            end else if (mline.size() < depth) begin
                mline.push_back(b);
                if (echo) expq.push_back(fold(b, up));
            end else begin
                movf = 1'b1;
            end
        end
    endtask

    initial begin
        int s, s2, nd, k, r;
        rst_v      = 3'b111;
        rx_valid_v = 3'b000;
        hold_v     = 3'b000;
        for (int g = 0; g < 3; g++) rx_byte_v[g] = 8'h00;
        idle(3);
        rst_v = 3'b000;
        for (int g = 0; g < 3; g++) check_reset(g, "reset");

        // Character echo latency on A.
        s = txq[0].size();
        send(0, 8'h61);
        chk("echo_valid_early", 32'(tx_valid_w[0]), 0);
        k = 0;
        while (!tx_valid_w[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("echo_latency", k, 3);
        chk("echo_tx_data", 32'(tx_data_w[0]), 32'h61);
        chk("echo_last_char", 32'(last_char_w[0]), 32'h61);
        chk("echo_line_len", len_of(0), 1);
        idle(30);
        chk("echo_count", 32'(txq[0].size() - s), 1);

        // Backspace editing and CR in echo mode.
        s = txq[0].size(); nd = ndone[0];
        stim = '{8'h61, 8'h62, 8'h08, 8'h0D};
        drive_stim(0, 30);
        idle(100);
        expq = '{8'h61, 8'h62, 8'h08, 8'h20, 8'h08, 8'h0D, 8'h0A};
        cmp_stream(0, s, "bscr");
        chk("bscr_line_len", len_of(0), 0);
        chk("bscr_line_done", ndone[0] - nd, 1);

        // Line replay with upper-case folding on B.
        s = txq[1].size();
        send(1, 8'h68);
        idle(20);
        send(1, 8'h69);
        idle(20);
        chk("replay_silent", 32'(txq[1].size() - s), 0);
        chk("replay_line_len", len_of(1), 2);
        send(1, 8'h0D);
        idle(120);
        expq = '{8'h48, 8'h49, 8'h0D, 8'h0A};
        cmp_stream(1, s, "replay");
        chk("replay_len_end", len_of(1), 0);

        // Line overflow on B (4-byte line).
        s = txq[1].size(); nd = ndone[1];
        stim = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        drive_stim(1, 10);
        chk("ovf_flag_set", 32'(line_ovf_w[1]), 1);
        chk("ovf_line_len", len_of(1), 4);
        send(1, 8'h0D);
        idle(150);
        expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        cmp_stream(1, s, "ovf");
        chk("ovf_flag_clear", 32'(line_ovf_w[1]), 0);
        chk("ovf_line_done", ndone[1] - nd, 1);

        // FIFO stress on C: tx_done held off, four back-to-back bytes.
        s = txq[2].size();
        hold_v[2] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_valid_v[2] = 1'b1;
            rx_byte_v[2]  = 8'h70 + 8'(i);
            @(negedge clk);
        end
        rx_valid_v[2] = 1'b0;
        idle(20);
        chk("stress_rx_ovf", 32'(rx_ovf_w[2]), 1);
        chk("stress_inflight", 32'(txq[2].size() - s), 1);
        hold_v[2] = 1'b0;
        idle(100);
        expq = '{8'h70, 8'h71, 8'h72};
        cmp_stream(2, s, "stress");
        chk("stress_ovf_sticky", 32'(rx_ovf_w[2]), 1);

        // Reset in the middle of a replay on B.
        stim = '{8'h61, 8'h62, 8'h63};
        drive_stim(1, 10);
        s = txq[1].size();
        send(1, 8'h0D);
        k = 0;
        while (txq[1].size() == s && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_replay_started", 32'(k < 100), 1);
        idle(2);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        check_reset(1, "midrst");
        idle(20);
        s2 = txq[1].size();
        chk("midrst_no_resume", 32'(s2 - s), 1);
        send(1, 8'h7A);
        idle(20);
        chk("midrst_z_len", len_of(1), 1);
        send(1, 8'h0D);
        idle(100);
        expq = '{8'h5A, 8'h0D, 8'h0A};
        cmp_stream(1, s2, "midrst");

        // Randomized byte streams against the reference model on A and B.
        rst_v = 3'b011;
        @(negedge clk);
        rst_v = 3'b000;
        stim.delete();
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                6:       stim.push_back(8'h08);
                7:       stim.push_back(8'h7F);
                8:       stim.push_back(8'h0D);
                9:       stim.push_back(8'h0A);
                5:       stim.push_back(8'($urandom_range(8'h20, 8'h7E)));
                4:       stim.push_back(8'($urandom_range(8'h41, 8'h5A)));
                default: stim.push_back(8'($urandom_range(8'h61, 8'h7A)));
            endcase
        end
        for (int g = 0; g < 2; g++) begin
            s = txq[g].size();
            drive_stim(g, 40);
            idle(200);
            if (g == 0) run_model(64, 1'b1, 1'b0);
            else        run_model(4, 1'b0, 1'b1);
            cmp_stream(g, s, $sformatf("rand%0d", g));
            chk($sformatf("rand%0d_line_len", g), len_of(g), 32'(mline.size()));
            chk($sformatf("rand%0d_line_ovf", g), 32'(line_ovf_w[g]), 32'(movf));
            chk($sformatf("rand%0d_rx_ovf", g), 32'(rx_ovf_w[g]), 0);
        end

        for (int g = 0; g < 3; g++) begin
            chk($sformatf("tx_interlock%0d", g), viol[g], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
